// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and default constants for the I2C bus conditioner
//
// Purpose: bus state encoding and default parameter values used by
//          i2c_line_filter and i2c_bus_conditioner.
package i2c_pkg;

  typedef enum logic [1:0] {
    S_TBUF,
    S_FREE,
    S_BUSY
  } bus_state_e;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILTER_LEN  = 4;
  localparam int I2C_T_BUF       = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchroniser plus glitch filter for one open-drain line
//
// Purpose: brings an asynchronous pad level into the clock domain and only
//          accepts a new level once it has been stable for FILTER_LEN cycles.
//          Pin-to-filtered latency is SYNC_STAGES+FILTER_LEN cycles.
// Ports:
//   clock    in  system clock
//   rst      in  asynchronous active-high reset (line resets to 1, idle bus)
//   pin      in  raw pad level (async)
//   filtered out synchronised, de-glitched level
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic pin,
  output logic filtered
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // cnt holds how many consecutive cycles synced has disagreed with filtered;
  // any agreement restarts the count, so short pulses are discarded.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      filtered <= 1'b1;
      cnt      <= '0;
    end else if (synced != filtered) begin
      if (cnt == CW'(FILTER_LEN - 1)) begin
        filtered <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// rtl/i2c_bus_conditioner.sv - filtered SCL/SDA, edge pulses, START/STOP and bus state
//
// Purpose: conditions raw SCL/SDA pad reads for the I2C master: filtering,
//          SCL edge pulses, START/STOP detection, busy/free tracking with a
//          T_BUF idle guard, and optional arbitration-loss detection.
// Build option: define I2C_ARB_DETECT_EN to enable arb_lost; otherwise it is
//          tied 0 and sda_o/sda_t are ignored. Port list is the same either way.
// Ports:
//   clock, rst          clock, asynchronous active-high reset
//   scl_i, sda_i        raw pad levels (async)
//   sda_o, sda_t        master SDA output value and drive enable
//   scl_f, sda_f        filtered lines
//   scl_rise, scl_fall  1-cycle SCL edge pulses
//   start_det, stop_det 1-cycle START (incl. repeated) / STOP pulses
//   bus_busy, bus_free  bus state decodes
//   arb_lost            1-cycle arbitration-lost pulse
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILTER_LEN  = I2C_FILTER_LEN,
  parameter int T_BUF       = I2C_T_BUF
) (
  input  logic clock,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  input  logic sda_o,
  input  logic sda_t,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_free,
  output logic arb_lost
);

  localparam int TW = $clog2(T_BUF + 1);

  bus_state_e    state;
  logic [TW-1:0] tbuf_cnt;
  logic          scl_q;
  logic          sda_q;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clock    (clock),
    .rst      (rst),
    .pin      (scl_i),
    .filtered (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clock    (clock),
    .rst      (rst),
    .pin      (sda_i),
    .filtered (sda_f)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Conditions require SCL high on both sides of the SDA change, so an SCL
  // transition in the same cycle suppresses START/STOP.
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_q & scl_f & sda_q & ~sda_f;
  assign stop_det  = scl_q & scl_f & ~sda_q & sda_f;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= S_TBUF;
      tbuf_cnt <= '0;
    end else begin
      case (state)
        S_TBUF: begin
          if (start_det) begin
            state <= S_BUSY;
          end else if (scl_f && sda_f) begin
            if (tbuf_cnt != TW'(T_BUF)) tbuf_cnt <= tbuf_cnt + 1'b1;
            if (tbuf_cnt == TW'(T_BUF - 1)) state <= S_FREE;
          end else begin
            tbuf_cnt <= '0;
          end
        end
        S_FREE: begin
          if (start_det) begin
            state <= S_BUSY;
          end else if (!scl_f || !sda_f) begin
            state    <= S_TBUF;
            tbuf_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (stop_det) begin
            state    <= S_TBUF;
            tbuf_cnt <= '0;
          end
        end
        default: begin
          state    <= S_TBUF;
          tbuf_cnt <= '0;
        end
      endcase
    end
  end

  assign bus_busy = (state == S_BUSY);
  assign bus_free = (state == S_FREE);

`ifdef I2C_ARB_DETECT_EN
  // We released SDA (driving a 1) but the bus reads low when SCL rises.
  assign arb_lost = scl_rise & (state == S_BUSY) & sda_t & sda_o & ~sda_f;
`else
  logic unused_arb_inputs;
  assign unused_arb_inputs = sda_o ^ sda_t;
  assign arb_lost          = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb/tb_i2c_bus_conditioner.sv - self-checking bench for i2c_bus_conditioner
module tb_i2c_bus_conditioner;

  localparam int NS = 2;
  localparam int NF = 4;
  localparam int NT = 8;
`ifdef I2C_ARB_DETECT_EN
  localparam bit ARB_EN = 1'b1;
`else
  localparam bit ARB_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic scl_i = 1'b1;
  logic sda_i = 1'b1;
  logic sda_o = 1'b0;
  logic sda_t = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic bus_busy, bus_free, arb_lost;

  int checks = 0;
  int errors = 0;

  i2c_bus_conditioner dut (
    .clock     (clock),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .bus_free  (bus_free),
    .arb_lost  (arb_lost)
  );

  always #5 clock = ~clock;

  // Reference model: pin delay lines, run-length filter, bus tracker.
  logic dl_scl[$];
  logic dl_sda[$];
  logic m_scl, m_sda, m_scl_prev, m_sda_prev;
  int   run_scl, run_sda, idle_run;
  bit   m_busy, m_free;

  task automatic model_reset();
    dl_scl = {};
    dl_sda = {};
    for (int i = 0; i < NS; i++) begin
      dl_scl.push_back(1'b1);
      dl_sda.push_back(1'b1);
    end
    m_scl = 1; m_sda = 1; m_scl_prev = 1; m_sda_prev = 1;
    run_scl = 0; run_sda = 0; idle_run = 0;
    m_busy = 0; m_free = 0;
  endtask

  function automatic bit m_start();
    return m_scl_prev && m_scl && m_sda_prev && !m_sda;
  endfunction

  function automatic bit m_stop();
    return m_scl_prev && m_scl && !m_sda_prev && m_sda;
  endfunction

  task automatic model_edge(input logic s, input logic d);
    logic syn_s, syn_d;
    bit st, sp;
    st = m_start();
    sp = m_stop();
    if (m_busy) begin
      if (sp) begin m_busy = 0; idle_run = 0; end
    end else if (st) begin
      m_busy = 1; m_free = 0;
    end else if (m_free) begin
      if (!(m_scl && m_sda)) begin m_free = 0; idle_run = 0; end
    end else if (m_scl && m_sda) begin
      idle_run++;
      if (idle_run >= NT) m_free = 1;
    end else begin
      idle_run = 0;
    end
    syn_s = dl_scl[$];
    syn_d = dl_sda[$];
    m_scl_prev = m_scl;
    m_sda_prev = m_sda;
    // a new level is accepted after NF consecutive disagreeing samples
    if (syn_s != m_scl) begin
      run_scl++;
      if (run_scl == NF) begin m_scl = syn_s; run_scl = 0; end
    end else run_scl = 0;
    if (syn_d != m_sda) begin
      run_sda++;
      if (run_sda == NF) begin m_sda = syn_d; run_sda = 0; end
    end else run_sda = 0;
    dl_scl.push_front(s); void'(dl_scl.pop_back());
    dl_sda.push_front(d); void'(dl_sda.pop_back());
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit rise;
    rise = m_scl && !m_scl_prev;
    check("m_scl_f", scl_f, m_scl);
    check("m_sda_f", sda_f, m_sda);
    check("m_scl_rise", scl_rise, rise);
    check("m_scl_fall", scl_fall, !m_scl && m_scl_prev);
    check("m_start", start_det, m_start());
    check("m_stop", stop_det, m_stop());
    check("m_busy", bus_busy, m_busy);
    check("m_free", bus_free, m_free);
    check("m_arb", arb_lost, ARB_EN && rise && m_busy && sda_t && sda_o && !m_sda);
  endtask

  task automatic step(input logic s, input logic d);
    scl_i = s;
    sda_i = d;
    @(posedge clock);
    model_edge(s, d);
    @(negedge clock);
    check_model();
  endtask

  initial begin
    int falls, starts, stops;
    logic cs, cd;

    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_scl_f", scl_f, 1'b1);
    check("rst_sda_f", sda_f, 1'b1);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_free", bus_free, 1'b0);
    check("rst_start", start_det, 1'b0);
    rst = 1'b0;

    // 1: bus_free after exactly 8 idle cycles
    for (int i = 0; i < 12; i++) begin
      step(1, 1);
      check("t1_free", bus_free, i >= NT - 1);
      check("t1_busy", bus_busy, 1'b0);
    end

    // 2: START latency 2+4, busy the cycle after
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      check("t2_start", start_det, i == NS + NF - 1);
      check("t2_busy", bus_busy, i >= NS + NF);
    end
    for (int i = 0; i < 8; i++) step(0, 0);
    for (int i = 0; i < 8; i++) step(1, 0);

    // 3: 3-cycle SCL glitch dropped, 4-cycle low accepted once
    falls = 0;
    for (int i = 0; i < 3; i++) begin step(0, 0); falls += scl_fall; end
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      falls += scl_fall;
      check("t3_glitch_scl", scl_f, 1'b1);
    end
    check("t3_no_fall", falls != 0, 1'b0);
    falls = 0;
    for (int i = 0; i < 4; i++) begin step(0, 0); falls += scl_fall; end
    for (int i = 0; i < 8; i++) begin step(1, 0); falls += scl_fall; end
    check("t3_one_fall", falls == 1, 1'b1);

    // 4: repeated START keeps busy, then STOP and T_BUF
    starts = 0;
    for (int i = 0; i < 8; i++) step(0, 0);
    for (int i = 0; i < 8; i++) step(0, 1);
    for (int i = 0; i < 8; i++) step(1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      starts += start_det;
      check("t4_busy", bus_busy, 1'b1);
    end
    check("t4_rstart", starts == 1, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0);
    for (int i = 0; i < 8; i++) step(1, 0);
    stops = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1);
      stops += stop_det;
      check("t4_stop_pulse", stop_det, i == NS + NF - 1);
      check("t4_free", bus_free, i >= NS + NF + NT);
    end
    check("t4_one_stop", stops == 1, 1'b1);

    // 5: simultaneous fall -> scl_fall only
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      check("t5_no_start", start_det, 1'b0);
      check("t5_fall", scl_fall, i == NS + NF - 1);
      check("t5_not_busy", bus_busy, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1, 1);

    // 6: arbitration loss on SCL rise while releasing SDA
    for (int i = 0; i < 8; i++) step(1, 0);
    for (int i = 0; i < 8; i++) step(0, 0);
    sda_t = 1'b1;
    sda_o = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      check("t6_arb", arb_lost, ARB_EN && (i == NS + NF - 1));
    end
    sda_t = 1'b0;
    sda_o = 1'b0;

    // randomized line activity against the model
    cs = 1; cd = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) cs = ~cs;
      if ($urandom_range(5) == 0) cd = ~cd;
      sda_o = 1'($urandom_range(1));
      sda_t = 1'($urandom_range(1));
      step(cs, cd);
    end

    // asynchronous reset mid-transfer
    for (int i = 0; i < 8; i++) step(1, 1);
    for (int i = 0; i < 8; i++) step(1, 0);
    check("rb_busy_before", bus_busy, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 0);
    #2 rst = 1'b1;
    #1;
    check("ra_scl_f", scl_f, 1'b1);
    check("ra_sda_f", sda_f, 1'b1);
    check("ra_busy", bus_busy, 1'b0);
    check("ra_free", bus_free, 1'b0);
    check("ra_fall", scl_fall, 1'b0);
    check("ra_rise", scl_rise, 1'b0);
    check("ra_start", start_det, 1'b0);
    check("ra_stop", stop_det, 1'b0);
    check("ra_arb", arb_lost, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      check("rr_free", bus_free, i >= NT - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
